// File: rtl/brch_pkg.sv
// Shared types for the branch-resolve stage: op encodings, resolve FSM state and ALU flags.
package brch_pkg;

   typedef enum logic [3:0] {
      OP_SEQ  = 4'd0,
      OP_SLT  = 4'd1,
      OP_SLE  = 4'd2,
      OP_SCO  = 4'd3,
      OP_BEQZ = 4'd4,
      OP_BNEZ = 4'd5,
      OP_BLTZ = 4'd6,
      OP_BGEZ = 4'd7,
      OP_JMP  = 4'd8
   } brch_op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SQUASH = 1'b1
   } brch_state_e;

   typedef struct packed {
      logic sf;
      logic zf;
      logic of;
      logic cf;
   } brch_flags_t;

endpackage

// File: rtl/brch_cond_eval.sv
// Combinational condition evaluator: turns an op code plus ALU flags into a set-compare
// result, a taken bit and a branch-class indication. Codes 9..15 behave as NOP.
module brch_cond_eval
   import brch_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        brch_ctrl,
   input  brch_flags_t       flags,
   output logic [DATA_W-1:0] cmp_result,
   output logic              taken,
   output logic              is_branch
);

   logic lt;
   logic cond;
   logic is_cmp;

   // Signed less-than from the subtract flags.
   assign lt = flags.sf ^ flags.of;

   always_comb begin
      cond      = 1'b0;
      is_cmp    = 1'b0;
      is_branch = 1'b0;
      case (brch_ctrl)
         OP_SEQ:  begin cond = flags.zf;       is_cmp = 1'b1;    end
         OP_SLT:  begin cond = lt;             is_cmp = 1'b1;    end
         OP_SLE:  begin cond = lt | flags.zf;  is_cmp = 1'b1;    end
         OP_SCO:  begin cond = flags.cf;       is_cmp = 1'b1;    end
         OP_BEQZ: begin cond = flags.zf;       is_branch = 1'b1; end
         OP_BNEZ: begin cond = ~flags.zf;      is_branch = 1'b1; end
         OP_BLTZ: begin cond = lt;             is_branch = 1'b1; end
         OP_BGEZ: begin cond = ~lt;            is_branch = 1'b1; end
         OP_JMP:  begin cond = 1'b1;           is_branch = 1'b1; end
         default: begin cond = 1'b0;                             end
      endcase
   end

   always_comb begin
      cmp_result    = '0;
      cmp_result[0] = is_cmp & cond;
      taken         = is_branch & cond;
   end

endmodule

// File: rtl/brch_resolve.sv
// Branch resolve stage: evaluates the op, registers results with latency 1, detects
// mispredicts and squashes the following SQUASH_CYC accepted cycles; keeps branch statistics.
module brch_resolve
   import brch_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int PC_W       = 16,
   parameter int SQUASH_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [3:0]        brch_ctrl,
   input  logic              sf,
   input  logic              zf,
   input  logic              of,
   input  logic              cf,
   input  logic [PC_W-1:0]   pc_plus2,
   input  logic [PC_W-1:0]   target,
   input  logic              pred_taken,
   input  logic              stall,
   input  logic              flush,
   input  logic              clr_cnt,
   output logic              valid_out,
   output logic [DATA_W-1:0] cmp_result,
   output logic              taken,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              squashing,
   output logic [CNT_W-1:0]  brch_cnt,
   output logic [CNT_W-1:0]  mis_cnt
);

   localparam logic [3:0]       SQ_LOAD = 4'(SQUASH_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   brch_flags_t       flags;
   logic [DATA_W-1:0] ev_cmp;
   logic              ev_taken;
   logic              ev_branch;
   logic              ev_mis;
   logic              accept;
   brch_state_e       state;
   logic [3:0]        sq_cnt;

   assign flags.sf = sf;
   assign flags.zf = zf;
   assign flags.of = of;
   assign flags.cf = cf;

   brch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
      .brch_ctrl  (brch_ctrl),
      .flags      (flags),
      .cmp_result (ev_cmp),
      .taken      (ev_taken),
      .is_branch  (ev_branch)
   );

   // Handshake: an op transfers on a rising edge with valid_in=1, stall=0, flush=0 and the
   // stage not squashing; there is no ready, so ops offered while squashing are dropped.
   // valid_out is high for one cycle per transferred op, longer only while stall freezes it.
   assign accept = valid_in && !stall && !flush && (state == ST_IDLE);
   assign ev_mis = ev_taken != pred_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sq_cnt      <= '0;
         squashing   <= 1'b0;
         valid_out   <= 1'b0;
         taken       <= 1'b0;
         mispredict  <= 1'b0;
         cmp_result  <= '0;
         redirect_pc <= '0;
      end else if (flush) begin
         state      <= ST_IDLE;
         sq_cnt     <= '0;
         squashing  <= 1'b0;
         valid_out  <= 1'b0;
         taken      <= 1'b0;
         mispredict <= 1'b0;
      end else if (!stall) begin
         if (accept) begin
            valid_out   <= 1'b1;
            cmp_result  <= ev_cmp;
            taken       <= ev_taken;
            mispredict  <= ev_mis;
            redirect_pc <= ev_taken ? target : pc_plus2;
            if (ev_mis) begin
               state     <= ST_SQUASH;
               squashing <= 1'b1;
               sq_cnt    <= SQ_LOAD;
            end
         end else begin
            valid_out  <= 1'b0;
            mispredict <= 1'b0;
            if (state == ST_SQUASH) begin
               // The edge that brings the count to zero is also the edge that leaves SQUASH.
               if (sq_cnt <= 4'd1) begin
                  state     <= ST_IDLE;
                  squashing <= 1'b0;
                  sq_cnt    <= '0;
               end else begin
                  sq_cnt <= sq_cnt - 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brch_cnt <= '0;
         mis_cnt  <= '0;
      end else if (clr_cnt) begin
         brch_cnt <= '0;
         mis_cnt  <= '0;
      end else if (accept) begin
         if (ev_branch && (brch_cnt != CNT_MAX)) brch_cnt <= brch_cnt + 1'b1;
         if (ev_mis && (mis_cnt != CNT_MAX))     mis_cnt  <= mis_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_brch_resolve.sv
// Bench for brch_resolve: directed scenarios then random traffic, each edge compared
// against a behavioural model of the stage kept in this file.
module tb_brch_resolve;

   localparam int DATA_W     = 16;
   localparam int PC_W       = 16;
   localparam int SQUASH_CYC = 2;
   localparam int CNT_W      = 4;
   localparam int CNT_SAT    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_in;
   logic [3:0]        brch_ctrl;
   logic              sf, zf, of, cf;
   logic [PC_W-1:0]   pc_plus2;
   logic [PC_W-1:0]   target;
   logic              pred_taken;
   logic              stall;
   logic              flush;
   logic              clr_cnt;
   logic              valid_out;
   logic [DATA_W-1:0] cmp_result;
   logic              taken;
   logic              mispredict;
   logic [PC_W-1:0]   redirect_pc;
   logic              squashing;
   logic [CNT_W-1:0]  brch_cnt;
   logic [CNT_W-1:0]  mis_cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit m_valid, m_taken, m_mis;
   int m_cmp, m_rpc, m_sq_left, m_brch, m_miscnt;

   always #5 clk = ~clk;

   brch_resolve #(
      .DATA_W(DATA_W), .PC_W(PC_W), .SQUASH_CYC(SQUASH_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .brch_ctrl(brch_ctrl),
      .sf(sf), .zf(zf), .of(of), .cf(cf), .pc_plus2(pc_plus2), .target(target),
      .pred_taken(pred_taken), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .valid_out(valid_out), .cmp_result(cmp_result), .taken(taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .squashing(squashing),
      .brch_cnt(brch_cnt), .mis_cnt(mis_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid_out"},   32'(valid_out),   32'(m_valid));
      check({tag, ".cmp_result"},  32'(cmp_result),  32'(m_cmp));
      check({tag, ".taken"},       32'(taken),       32'(m_taken));
      check({tag, ".mispredict"},  32'(mispredict),  32'(m_mis));
      check({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(m_rpc));
      check({tag, ".squashing"},   32'(squashing),   32'(m_sq_left > 0));
      check({tag, ".brch_cnt"},    32'(brch_cnt),    32'(m_brch));
      check({tag, ".mis_cnt"},     32'(mis_cnt),     32'(m_miscnt));
   endtask

   task automatic model_reset();
      m_valid = 0; m_taken = 0; m_mis = 0;
      m_cmp = 0; m_rpc = 0; m_sq_left = 0; m_brch = 0; m_miscnt = 0;
   endtask

   // Op semantics straight from the instruction table: compares set bit 0, branches redirect.
   function automatic void ref_eval(input int code, input bit f_sf, input bit f_zf,
                                    input bit f_of, input bit f_cf,
                                    output bit is_cmp, output bit is_br, output bit c);
      bit lt;
      lt = f_sf ^ f_of;
      case (code)
         0: c = f_zf;
         1: c = lt;
         2: c = lt | f_zf;
         3: c = f_cf;
         4: c = f_zf;
         5: c = !f_zf;
         6: c = lt;
         7: c = !lt;
         8: c = 1'b1;
         default: c = 1'b0;
      endcase
      is_cmp = (code <= 3);
      is_br  = (code >= 4) && (code <= 8);
   endfunction

   task automatic model_edge();
      bit is_cmp, is_br, c, acc, tk, mis;
      ref_eval(int'(brch_ctrl), sf, zf, of, cf, is_cmp, is_br, c);
      tk  = is_br && c;
      mis = (tk != pred_taken);
      acc = valid_in && !stall && !flush && (m_sq_left == 0);
      if (clr_cnt) begin
         m_brch = 0; m_miscnt = 0;
      end else if (acc) begin
         if (is_br && m_brch < CNT_SAT) m_brch++;
         if (mis && m_miscnt < CNT_SAT) m_miscnt++;
      end
      if (flush) begin
         m_valid = 0; m_mis = 0; m_taken = 0; m_sq_left = 0;
      end else if (!stall) begin
         if (acc) begin
            m_valid = 1;
            m_cmp   = (is_cmp && c) ? 1 : 0;
            m_taken = tk;
            m_mis   = mis;
            m_rpc   = tk ? int'(target) : int'(pc_plus2);
            if (mis) m_sq_left = SQUASH_CYC;
         end else begin
            m_valid = 0; m_mis = 0;
            if (m_sq_left > 0) m_sq_left--;
         end
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive_op(input bit v, input int code, input bit i_sf, input bit i_zf,
                           input bit i_of, input bit i_cf, input bit pred,
                           input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] pc2);
      valid_in = v; brch_ctrl = 4'(code);
      sf = i_sf; zf = i_zf; of = i_of; cf = i_cf;
      pred_taken = pred; target = tgt; pc_plus2 = pc2;
   endtask

   initial begin
      logic [CNT_W-1:0] saved_brch;
      rst_n = 1'b0;
      stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
      drive_op(0, 15, 0, 0, 0, 0, 0, '0, '0);
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // BEQZ taken but predicted not-taken: redirect to target and squash two cycles.
      drive_op(1, 4, 0, 1, 0, 0, 0, 16'h0040, 16'h0012);
      step("beqz");
      check("beqz.taken_const",  32'(taken),       32'd1);
      check("beqz.mis_const",    32'(mispredict),  32'd1);
      check("beqz.rpc_const",    32'(redirect_pc), 32'h0040);
      check("beqz.sq_const",     32'(squashing),   32'd1);
      drive_op(0, 15, 0, 0, 0, 0, 0, '0, '0);
      step("beqz_sq1");
      check("beqz.sq1_const", 32'(squashing), 32'd1);
      step("beqz_sq2");
      check("beqz.sq2_const", 32'(squashing), 32'd0);

      // SLE with sf!=of -> set; NOP code always yields zero.
      drive_op(1, 2, 1, 0, 0, 0, 0, 16'h1111, 16'h2222);
      step("sle");
      check("sle.cmp_const",   32'(cmp_result), 32'h0001);
      check("sle.taken_const", 32'(taken),      32'd0);
      drive_op(1, 15, 1, 0, 0, 0, 0, 16'h1111, 16'h2222);
      step("nop");
      check("nop.cmp_const", 32'(cmp_result), 32'h0000);

      // Mispredict followed by a 3-cycle stall: squash stretches, offered ops not counted.
      clr_cnt = 1'b1;
      drive_op(1, 8, 0, 0, 0, 0, 0, 16'h0300, 16'h0302);
      step("stall_mis");
      clr_cnt = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall_hold");
      check("stall.sq_held", 32'(squashing), 32'd1);
      stall = 1'b0;
      step("stall_sq_a");
      check("stall.sq_a", 32'(squashing), 32'd1);
      step("stall_sq_b");
      check("stall.sq_b", 32'(squashing), 32'd0);
      check("stall.brch_const", 32'(brch_cnt), 32'd0);
      check("stall.mis_const",  32'(mis_cnt),  32'd0);
      drive_op(0, 15, 0, 0, 0, 0, 0, '0, '0);
      step("stall_idle");

      // Flush with stall while an op is presented and the stage is squashing.
      drive_op(1, 5, 0, 0, 0, 0, 0, 16'h0500, 16'h0502);
      step("flush_mis");
      drive_op(0, 15, 0, 0, 0, 0, 0, '0, '0);
      flush = 1'b1; stall = 1'b1;
      step("flush");
      check("flush.valid_const", 32'(valid_out), 32'd0);
      check("flush.sq_const",    32'(squashing), 32'd0);
      flush = 1'b0; stall = 1'b0;

      // 17 correctly predicted JMPs saturate the 4-bit branch counter.
      clr_cnt = 1'b1;
      step("clr");
      clr_cnt = 1'b0;
      drive_op(1, 8, 0, 0, 0, 0, 1, 16'h0700, 16'h0702);
      for (int i = 0; i < 17; i++) step("jmp_sat");
      check("sat.brch_const", 32'(brch_cnt), 32'hF);
      check("sat.mis_const",  32'(mis_cnt),  32'h0);
      clr_cnt = 1'b1;
      step("clr_jmp");
      check("clr_jmp.brch_const", 32'(brch_cnt), 32'h0);
      clr_cnt = 1'b0;

      // Reset asserted between clock edges while squashing.
      drive_op(1, 8, 0, 0, 0, 0, 0, 16'h0900, 16'h0902);
      step("rst_mis");
      drive_op(0, 15, 0, 0, 0, 0, 0, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      drive_op(1, 8, 0, 0, 0, 0, 0, 16'h0A00, 16'h0A02);
      step("post_rst");
      check("post_rst.mis_const", 32'(mispredict), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive_op($urandom_range(0, 9) < 7, $urandom_range(0, 15),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  PC_W'($urandom), PC_W'($urandom));
         stall   = ($urandom_range(0, 9) < 2);
         flush   = ($urandom_range(0, 19) == 0);
         clr_cnt = ($urandom_range(0, 19) == 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/brch_resolve.md
BRCH_RESOLVE -- requirements
Module: brch_resolve

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of cmp_result.
REQ-002 SHALL have parameter PC_W, default 16, width of PC fields.
REQ-003 SHALL have parameter SQUASH_CYC, default 2, legal range 1..15, number of accepted cycles squashed after a mispredict.
REQ-004 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-005 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: valid_in in 1 op present; brch_ctrl in 4 op code; sf, zf, of, cf in 1 each ALU flags; pc_plus2 in PC_W fall-through PC; target in PC_W taken PC; pred_taken in 1 front-end prediction.
REQ-008 SHALL have ports: stall in 1 hold stage; flush in 1 kill stage and squash state; clr_cnt in 1 synchronous counter clear.
REQ-009 SHALL have outputs: valid_out 1; cmp_result DATA_W; taken 1; mispredict 1; redirect_pc PC_W; squashing 1; brch_cnt CNT_W; mis_cnt CNT_W, all registered.

Function
REQ-010 SHALL decode brch_ctrl: 0000 SEQ, 0001 SLT, 0010 SLE, 0011 SCO, 0100 BEQZ, 0101 BNEZ, 0110 BLTZ, 0111 BGEZ, 1000 JMP, 1001-1111 NOP.
REQ-011 SHALL compute conditions: SEQ/BEQZ = zf; BNEZ = ~zf; SLT/BLTZ = sf^of; BGEZ = ~(sf^of); SLE = (sf^of)|zf; SCO = cf; JMP = 1.
REQ-012 SHALL drive cmp_result = zero-extended condition bit at bit 0 for SEQ/SLT/SLE/SCO, all zeros for every other code (never high-impedance).
REQ-013 SHALL drive taken = condition for BEQZ..JMP, 0 for compare and NOP codes.
REQ-014 SHALL define mispredict = taken != pred_taken for every valid op, including non-branch ops with pred_taken=1.
REQ-015 SHALL drive redirect_pc = target when taken, else pc_plus2.
REQ-016 SHALL define an accept as a rising edge with valid_in=1, stall=0, flush=0, state IDLE; all results appear one cycle after accept (latency 1).
REQ-017 SHALL, on stall=1 and flush=0, hold every output and all state unchanged, including the squash counter.
REQ-018 SHALL, on flush=1, clear valid_out, mispredict and taken at the next edge and force state IDLE, regardless of stall.
REQ-019 SHALL, on a non-stalled, non-flushed edge without accept, clear valid_out and mispredict.
REQ-020 SHALL implement a two-state FSM: IDLE, SQUASH; squashing=1 in SQUASH.
REQ-021 SHALL transition IDLE->SQUASH at the accepting edge of a mispredicting op, loading the squash counter with SQUASH_CYC.
REQ-022 SHALL, in SQUASH, treat valid_in as 0, decrement the counter on each non-stalled edge, and return to IDLE on the edge where counter reaches 0.
REQ-023 SHALL increment brch_cnt on each accepted op with code BEQZ..JMP, and mis_cnt on each accepted mispredicting op; both saturate at all-ones.
REQ-024 SHALL clear both counters on clr_cnt=1, with clr_cnt taking priority over a simultaneous increment.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state IDLE, squash counter 0, counters 0, valid_out 0, taken 0, mispredict 0, squashing 0, cmp_result 0, redirect_pc 0.
REQ-026 SHALL leave reset release synchronous; first accept possible on the first edge after rst_n rises.

Structure
REQ-027 SHALL place brch_ctrl encodings (enum), the FSM state type and a flags struct {sf,zf,of,cf} in shared package brch_pkg.
REQ-028 SHALL implement condition evaluation (REQ-011..013) in one combinational sub-module brch_cond_eval, reused by later units.

Verification
REQ-029 SHALL cover: BEQZ, zf=1, pred_taken=0, target=0x0040, pc_plus2=0x0012 -> next cycle taken=1, mispredict=1, redirect_pc=0x0040, squashing=1 for 2 non-stalled cycles.
REQ-030 SHALL cover: SLE, sf=1, of=0, zf=0 -> cmp_result=0x0001, taken=0; same with code NOP -> cmp_result=0x0000.
REQ-031 SHALL cover: mispredict then stall=1 for 3 cycles during SQUASH -> squashing held 3 extra cycles, valid_in during squash not counted.
REQ-032 SHALL cover: flush=1 with stall=1 while valid_out=1 and SQUASH -> next cycle valid_out=0, squashing=0.
REQ-033 SHALL cover: CNT_W=4, 17 accepted JMPs with pred_taken=1 -> brch_cnt=0xF, mis_cnt=0; clr_cnt with simultaneous JMP -> brch_cnt=0.
REQ-034 SHALL cover: rst_n asserted mid-SQUASH, asynchronous to clk -> all outputs 0 immediately, state IDLE after release.
